ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
Two-requester arbiter in front of the processor's single AHB master port (ahb_en / ahb_wr_en / ahb_addr / ahb_wr_data / ahb_rd_data / ahb_rd_vld / ahb_busy / ahb_data_size). Requester 0 is the core load/store path; requester 1 is a secondary master (DMA/debug). The block grants the port with round-robin fairness, sequences one transfer at a time and routes completion back to the owner. A timeout aborts transfers that never complete.

Parameters:
TO_W, 8, width of the completion-timeout counter; timeout fires when the counter reaches 2^TO_W-1 (255 by default).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
arb_en  input  1  high = new grants allowed; an in-flight transfer always completes
m0_req, m1_req  input  1 each  transfer request, held until ack
m0_wr_en, m1_wr_en  input  1 each  1 = write, 0 = read
m0_addr, m1_addr  input  32 each  address
m0_wr_data, m1_wr_data  input  32 each  write data
m0_size, m1_size  input  2 each  data size code, passed through unchanged
m0_ack, m1_ack  output  1 each  one-cycle accept pulse; payload captured
m0_rd_data, m1_rd_data  output  32 each  read data, valid while rd_vld is high
m0_rd_vld, m1_rd_vld  output  1 each  one-cycle read-completion pulse
m0_done, m1_done  output  1 each  one-cycle completion pulse (read or write)
m0_err, m1_err  output  1 each  one-cycle timeout pulse
ahb_en  output  1  one-cycle transfer strobe
ahb_wr_en  output  1  registered direction
ahb_addr  output  32  registered address
ahb_wr_data  output  32  registered write data
ahb_data_size  output  2  registered size
ahb_rd_data  input  32  read data
ahb_rd_vld  input  1  read data valid
ahb_busy  input  1  slave busy / transfer outstanding

Behaviour:
- Sync reset (rst_n sampled low at a clk edge): state=IDLE. All outputs are 0. Timeout counter is 0. last_owner=1, so m0 wins the first tie. Reset mid-transfer abandons the transfer; a later ahb_rd_vld is ignored.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if arb_en=1 and ahb_busy=0 and any req=1 at edge N:
  - Pick the owner. With a single requester, that requester wins. With both, the winner is the requester that is not last_owner.
  - Capture the owner's wr_en/addr/wr_data/size into the ahb_* registers.
  - Set owner_ack=1 and ahb_en=1, set last_owner=owner, and go to ISSUE. Both signals are high for exactly the cycle after edge N.
  - Otherwise stay in IDLE.
- ISSUE: at the next edge, clear ack and ahb_en, clear the counter, and go to WAIT. The ahb_* payload registers hold their value until the next grant.
- WAIT (read):
  - When ahb_rd_vld is sampled 1 at edge M: owner_rd_data=ahb_rd_data, and owner_rd_vld=1 and owner_done=1 for the one cycle after M.
  - Go to IDLE.
- WAIT (write): when ahb_busy is sampled 0, pulse owner_done and go to IDLE. A zero-wait slave therefore completes at the first WAIT edge.
- Timeout: in WAIT, the counter increments on each edge without completion. When the counter equals 2^TO_W-1 and there is still no completion, pulse owner_err (done stays 0) and go to IDLE.
- Completion and timeout on the same edge: completion wins and err is not asserted.
- m*_rd_data holds its last value until the next read completion for that requester.
- Minimum cost per transfer is 3 cycles (IDLE, ISSUE, WAIT). Back-to-back: a req sampled at the completion edge M is not granted at M; the next grant is sampled at M+1, giving ahb_en at M+2.
- ahb_rd_vld sampled in IDLE or ISSUE is ignored.
- arb_en=0 blocks only the IDLE grant decision.
- A req deasserted before ack is simply not granted. The payload must be stable while req=1.

Test Plan:
- Single read: m0 read, addr 0x0000_1000, size 2; rd_vld with 0xDEADBEEF 3 cycles after ahb_en -> ahb_en is a 1-cycle pulse with addr 0x1000 and wr_en 0; m0_rd_data=0xDEADBEEF; m0_rd_vld and m0_done pulse together; m1 outputs stay 0.
- Round-robin: both requesters hold req continuously from reset -> grant order m0, m1, m0, m1; each ack is 1 cycle; ahb_en pulses are spaced by the completion latency plus 2.
- Zero-wait write: m1 write, addr 0x40, data 0x1234_5678, ahb_busy held 0 -> ahb_wr_data=0x12345678; m1_done 2 cycles after m1_ack; m1_rd_vld stays 0.
- Timeout: m0 read with ahb_rd_vld never asserted and TO_W=4 -> m0_err pulses 15 cycles after entry to WAIT, with no done. A rd_vld injected afterwards in IDLE produces no pulse.
- arb_en and busy gating: with arb_en=0 and m0_req=1 for 10 cycles -> no ack. Raise arb_en while ahb_busy=1 -> still no ack. Drop busy -> ack on the next cycle.
- Reset mid-WAIT: assert rst_n=0 for 1 edge during a read -> all outputs are 0 next cycle and the FSM is in IDLE. Subsequent rd_vld is ignored, and m0 wins the next simultaneous request.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Two-requester round-robin arbiter for the single AHB master port.
// One transfer in flight at a time; completion or timeout is routed back to the owner.
module ahb_master_arbiter #(
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arb_en,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wr_en,
    input  logic        m1_wr_en,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wr_data,
    input  logic [31:0] m1_wr_data,
    input  logic [1:0]  m0_size,
    input  logic [1:0]  m1_size,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rd_data,
    output logic [31:0] m1_rd_data,
    output logic        m0_rd_vld,
    output logic        m1_rd_vld,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output logic        ahb_en,
    output logic        ahb_wr_en,
    output logic [31:0] ahb_addr,
    output logic [31:0] ahb_wr_data,
    output logic [1:0]  ahb_data_size,
    input  logic [31:0] ahb_rd_data,
    input  logic        ahb_rd_vld,
    input  logic        ahb_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nxt;
    logic            grant;
    logic            pick;
    logic            complete;

    always_comb begin
        grant    = arb_en && !ahb_busy && (m0_req || m1_req);
        // m1 wins when alone, or on a tie when m0 owned the port last.
        pick     = m1_req && (!m0_req || !last_owner);
        // ahb_wr_en still holds the direction of the transfer in flight.
        complete = ahb_wr_en ? !ahb_busy : ahb_rd_vld;
        cnt_nxt  = cnt + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            cnt           <= '0;
            m0_ack        <= 1'b0;
            m1_ack        <= 1'b0;
            m0_rd_data    <= '0;
            m1_rd_data    <= '0;
            m0_rd_vld     <= 1'b0;
            m1_rd_vld     <= 1'b0;
            m0_done       <= 1'b0;
            m1_done       <= 1'b0;
            m0_err        <= 1'b0;
            m1_err        <= 1'b0;
            ahb_en        <= 1'b0;
            ahb_wr_en     <= 1'b0;
            ahb_addr      <= '0;
            ahb_wr_data   <= '0;
            ahb_data_size <= '0;
        end else begin
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            ahb_en    <= 1'b0;
            m0_rd_vld <= 1'b0;
            m1_rd_vld <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        owner         <= pick;
                        last_owner    <= pick;
                        ahb_wr_en     <= pick ? m1_wr_en   : m0_wr_en;
                        ahb_addr      <= pick ? m1_addr    : m0_addr;
                        ahb_wr_data   <= pick ? m1_wr_data : m0_wr_data;
                        ahb_data_size <= pick ? m1_size    : m0_size;
                        m0_ack        <= !pick;
                        m1_ack        <= pick;
                        ahb_en        <= 1'b1;
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (complete) begin
                        if (!ahb_wr_en) begin
                            if (owner) begin
                                m1_rd_data <= ahb_rd_data;
                                m1_rd_vld  <= 1'b1;
                            end else begin
                                m0_rd_data <= ahb_rd_data;
                                m0_rd_vld  <= 1'b1;
                            end
                        end
                        m0_done <= !owner;
                        m1_done <= owner;
                        state   <= IDLE;
                    end else if (cnt_nxt == CNT_MAX) begin
                        // Abort on the edge the wait count reaches all-ones.
                        m0_err <= !owner;
                        m1_err <= owner;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: transaction-level model compared every cycle,
// plus literal expectations for the scenarios of interest.
module tb_ahb_master_arbiter;

    localparam int TO       = 4;
    localparam int TO_EDGES = 1 << TO;   // edges from grant to the abort edge

    logic        clk = 1'b0;
    logic        rst_n, arb_en;
    logic        m0_req, m1_req, m0_wr_en, m1_wr_en;
    logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
    logic [1:0]  m0_size, m1_size;
    logic        m0_ack, m1_ack, m0_rd_vld, m1_rd_vld;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic        ahb_en, ahb_wr_en;
    logic [31:0] ahb_addr, ahb_wr_data, ahb_rd_data;
    logic [1:0]  ahb_data_size;
    logic        ahb_rd_vld, ahb_busy;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.TO_W(TO)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_wr_en(m0_wr_en), .m1_wr_en(m1_wr_en),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
        .m0_size(m0_size), .m1_size(m1_size),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
        .m0_rd_vld(m0_rd_vld), .m1_rd_vld(m1_rd_vld),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err),
        .ahb_en(ahb_en), .ahb_wr_en(ahb_wr_en), .ahb_addr(ahb_addr),
        .ahb_wr_data(ahb_wr_data), .ahb_data_size(ahb_data_size),
        .ahb_rd_data(ahb_rd_data), .ahb_rd_vld(ahb_rd_vld), .ahb_busy(ahb_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        e_m0_ack, e_m1_ack, e_m0_rd_vld, e_m1_rd_vld;
    logic        e_m0_done, e_m1_done, e_m0_err, e_m1_err, e_ahb_en, e_ahb_wr_en;
    logic [31:0] e_m0_rd_data, e_m1_rd_data, e_ahb_addr, e_ahb_wr_data;
    logic [1:0]  e_ahb_size;
    bit          busy_xfer;     // a transfer is owned
    bit          xfer_owner;
    bit          prev_owner;
    int          edges;         // edges elapsed since the grant edge

    always @(posedge clk) begin
        e_m0_ack = 0; e_m1_ack = 0; e_ahb_en = 0;
        e_m0_rd_vld = 0; e_m1_rd_vld = 0;
        e_m0_done = 0; e_m1_done = 0; e_m0_err = 0; e_m1_err = 0;
        if (!rst_n) begin
            busy_xfer = 0; prev_owner = 1; xfer_owner = 0; edges = 0;
            e_m0_rd_data = 0; e_m1_rd_data = 0; e_ahb_wr_en = 0;
            e_ahb_addr = 0; e_ahb_wr_data = 0; e_ahb_size = 0;
        end else if (busy_xfer) begin
            edges++;
            if (edges >= 2) begin
                if (e_ahb_wr_en ? !ahb_busy : ahb_rd_vld) begin
                    if (!e_ahb_wr_en) begin
                        if (xfer_owner) begin e_m1_rd_data = ahb_rd_data; e_m1_rd_vld = 1; end
                        else            begin e_m0_rd_data = ahb_rd_data; e_m0_rd_vld = 1; end
                    end
                    if (xfer_owner) e_m1_done = 1; else e_m0_done = 1;
                    busy_xfer = 0;
                end else if (edges == TO_EDGES) begin
                    if (xfer_owner) e_m1_err = 1; else e_m0_err = 1;
                    busy_xfer = 0;
                end
            end
        end else if (arb_en && !ahb_busy && (m0_req || m1_req)) begin
            xfer_owner = (m0_req && m1_req) ? !prev_owner : m1_req;
            prev_owner = xfer_owner;
            busy_xfer  = 1;
            edges      = 0;
            e_ahb_en   = 1;
            if (xfer_owner) begin
                e_m1_ack = 1; e_ahb_wr_en = m1_wr_en; e_ahb_addr = m1_addr;
                e_ahb_wr_data = m1_wr_data; e_ahb_size = m1_size;
            end else begin
                e_m0_ack = 1; e_ahb_wr_en = m0_wr_en; e_ahb_addr = m0_addr;
                e_ahb_wr_data = m0_wr_data; e_ahb_size = m0_size;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m0_ack", m0_ack, e_m0_ack);
            chk("m1_ack", m1_ack, e_m1_ack);
            chk("m0_rd_data", m0_rd_data, e_m0_rd_data);
            chk("m1_rd_data", m1_rd_data, e_m1_rd_data);
            chk("m0_rd_vld", m0_rd_vld, e_m0_rd_vld);
            chk("m1_rd_vld", m1_rd_vld, e_m1_rd_vld);
            chk("m0_done", m0_done, e_m0_done);
            chk("m1_done", m1_done, e_m1_done);
            chk("m0_err", m0_err, e_m0_err);
            chk("m1_err", m1_err, e_m1_err);
            chk("ahb_en", ahb_en, e_ahb_en);
            chk("ahb_wr_en", ahb_wr_en, e_ahb_wr_en);
            chk("ahb_addr", ahb_addr, e_ahb_addr);
            chk("ahb_wr_data", ahb_wr_data, e_ahb_wr_data);
            chk("ahb_data_size", {30'd0, ahb_data_size}, {30'd0, e_ahb_size});
        end
    end

    task automatic wait_ack(input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (m0_ack || m1_ack) begin
                ok = 1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got no ack expected ack within 50 cycles", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int who[$];
        int cyc[$];
        int dly;
        bit seen;

        rst_n = 0; arb_en = 1;
        m0_req = 0; m1_req = 0; m0_wr_en = 0; m1_wr_en = 0;
        m0_addr = 0; m1_addr = 0; m0_wr_data = 0; m1_wr_data = 0;
        m0_size = 0; m1_size = 0;
        ahb_rd_data = 0; ahb_rd_vld = 0; ahb_busy = 0;
        tick(2);
        cmp_en = 1;
        chk("reset_ahb_en", ahb_en, 0);
        chk("reset_m0_ack", m0_ack, 0);
        chk("reset_addr", ahb_addr, 0);
        rst_n = 1;
        tick(1);

        // Single read from m0
        m0_req = 1; m0_wr_en = 0; m0_addr = 32'h0000_1000; m0_size = 2'd2;
        wait_ack("read_ack");
        chk("read_ahb_en", ahb_en, 1);
        chk("read_addr", ahb_addr, 32'h0000_1000);
        chk("read_wr_en", ahb_wr_en, 0);
        chk("read_size", {30'd0, ahb_data_size}, 32'd2);
        m0_req = 0;
        tick(1);
        chk("read_en_pulse", ahb_en, 0);
        tick(1);
        ahb_rd_data = 32'hDEAD_BEEF; ahb_rd_vld = 1;
        tick(1);
        ahb_rd_vld = 0;
        chk("read_data", m0_rd_data, 32'hDEAD_BEEF);
        chk("read_vld", m0_rd_vld, 1);
        chk("read_done", m0_done, 1);
        chk("read_m1_done", m1_done, 0);
        tick(2);

        // Zero-wait write from m1
        m1_req = 1; m1_wr_en = 1; m1_addr = 32'h40; m1_wr_data = 32'h1234_5678; m1_size = 2'd2;
        wait_ack("wr_ack");
        chk("wr_m1_ack", m1_ack, 1);
        chk("wr_data", ahb_wr_data, 32'h1234_5678);
        m1_req = 0;
        tick(2);
        chk("wr_done", m1_done, 1);
        chk("wr_rd_vld", m1_rd_vld, 0);
        tick(2);

        // Round-robin with both requesters held (writes, zero-wait)
        m0_wr_en = 1; m0_addr = 32'h100; m0_wr_data = 32'hA0A0_A0A0;
        m1_wr_en = 1; m1_addr = 32'h200; m1_wr_data = 32'hB1B1_B1B1;
        m0_req = 1; m1_req = 1;
        for (int c = 0; c < 40 && who.size() < 4; c++) begin
            tick(1);
            if (m0_ack) begin who.push_back(0); cyc.push_back(c); end
            if (m1_ack) begin who.push_back(1); cyc.push_back(c); end
        end
        m0_req = 0; m1_req = 0;
        chk("rr_count", who.size(), 4);
        if (who.size() == 4) begin
            chk("rr_g0", who[0], 0);
            chk("rr_g1", who[1], 1);
            chk("rr_g2", who[2], 0);
            chk("rr_g3", who[3], 1);
            chk("rr_gap1", cyc[1] - cyc[0], 3);
            chk("rr_gap3", cyc[3] - cyc[2], 3);
        end
        tick(4);

        // Timeout on a read that never returns
        m0_req = 1; m0_wr_en = 0; m0_addr = 32'h2000;
        wait_ack("to_ack");
        m0_req = 0;
        dly = -1;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (m0_err) begin
                dly = c;
                chk("to_no_done", m0_done, 0);
                break;
            end
        end
        chk("to_delay", dly, TO_EDGES);
        ahb_rd_data = 32'h5555_AAAA; ahb_rd_vld = 1;
        tick(1);
        ahb_rd_vld = 0;
        chk("to_late_vld", m0_rd_vld, 0);
        chk("to_late_data", m0_rd_data, 32'hDEAD_BEEF);
        tick(2);

        // arb_en and busy gating
        arb_en = 0; m0_req = 1; m0_wr_en = 1; m0_addr = 32'h300;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (m0_ack) seen = 1;
        end
        chk("gate_arb_en", seen, 0);
        ahb_busy = 1; arb_en = 1;
        tick(3);
        chk("gate_busy", m0_ack, 0);
        ahb_busy = 0;
        tick(1);
        chk("gate_release", m0_ack, 1);
        m0_req = 0;
        tick(4);

        // Reset in the middle of a read
        m0_req = 1; m0_wr_en = 0; m0_addr = 32'h400;
        wait_ack("rst_ack");
        m0_req = 0;
        tick(2);
        rst_n = 0;
        tick(1);
        chk("rst_ahb_en", ahb_en, 0);
        chk("rst_addr", ahb_addr, 0);
        chk("rst_rd_data", m0_rd_data, 0);
        chk("rst_err", m0_err, 0);
        rst_n = 1;
        ahb_rd_data = 32'hCAFE_F00D; ahb_rd_vld = 1;
        tick(1);
        ahb_rd_vld = 0;
        chk("rst_late_vld", m0_rd_vld, 0);
        chk("rst_late_data", m0_rd_data, 0);
        m0_wr_en = 1; m1_wr_en = 1;
        m0_req = 1; m1_req = 1;
        tick(1);
        chk("rst_tie_m0", m0_ack, 1);
        chk("rst_tie_m1", m1_ack, 0);
        m0_req = 0; m1_req = 0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
